// File: rtl/bus_slave_if_pkg.sv
// Shared bus definitions for the generic bus slave: state encoding,
// handshake polarities and the data word width.
package bus_slave_if_pkg;

   localparam int STATE_W     = 2;
   localparam int WORD_DATA_W = 32;
   localparam int WAIT_W      = 4;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic RESET_ENABLE  = 1'b1;
   localparam logic RESET_ENABLE_ = 1'b0;

   typedef enum logic [STATE_W-1:0] {
      BUS_SLAVE_STATE_IDLE   = 2'h0,
      BUS_SLAVE_STATE_ACCESS = 2'h1,
      BUS_SLAVE_STATE_DONE   = 2'h2
   } bus_slave_state_e;

endpackage

// File: rtl/bus_slave_if_if.sv
// Bus-side handshake and data signals between a bus master and the slave.
interface bus_slave_if_if;
   import bus_slave_if_pkg::*;

   logic                   cs_;
   logic                   as_;
   logic                   rw;
   logic [WORD_DATA_W-1:0] addr;
   logic [WORD_DATA_W-1:0] wr_data;
   logic [WORD_DATA_W-1:0] rd_data;
   logic                   rdy_;

   modport master (
      output cs_, as_, rw, addr, wr_data,
      input  rd_data, rdy_
   );

   modport slave (
      input  cs_, as_, rw, addr, wr_data,
      output rd_data, rdy_
   );

endinterface

// File: rtl/bus_slave_if_ram.sv
// Single-port synchronous word RAM with a registered read port. The read
// register doubles as the slave's rd_data output, so it is zero whenever
// no read is being returned.
module bus_slave_ram
   import bus_slave_if_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [WORD_DATA_W-1:0] wr_data,
   output logic [WORD_DATA_W-1:0] rd_data
);

   logic [WORD_DATA_W-1:0] mem [2**ADDR_W];

   // Commit a write; the contents survive reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wr_data;
      end
   end

   // Present the addressed word for one cycle on a read, zero otherwise.
   always_ff @(posedge clk) begin
      if (reset == RESET_ENABLE_) begin
         rd_data <= '0;
      end else if (en && !we) begin
         rd_data <= mem[addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: rtl/bus_slave_if.sv
// Generic bus slave: accepts one master access, waits WAIT_CYCLES extra
// cycles, performs the RAM access and answers with a one-cycle rdy_ pulse.
module bus_slave_if
   import bus_slave_if_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input logic           clk,
   input logic           reset,
   bus_slave_if_if.slave bus
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

   bus_slave_state_e       state;
   logic [WAIT_W-1:0]      cnt;
   logic                   rw_q;
   logic [ADDR_W-1:0]      idx_q;
   logic [WORD_DATA_W-1:0] wr_data_q;
   logic                   rdy_q;
   logic                   ram_en;
   logic [WORD_DATA_W-1:0] ram_rd_data;
   logic                   unused_addr_bits;

   // Only the word index selects a RAM word; upper and byte-lane bits drop out.
   assign unused_addr_bits = ^{bus.addr[WORD_DATA_W-1:ADDR_W+2], bus.addr[1:0]};

   // The RAM is touched only on the final ACCESS edge, and never under reset,
   // so an aborted write cannot reach memory.
   assign ram_en = (reset != RESET_ENABLE_) &&
                   (state == BUS_SLAVE_STATE_ACCESS) && (cnt == '0);

   // Access sequencer: latch the request, count wait states, pulse ready.
   always_ff @(posedge clk) begin
      if (reset == RESET_ENABLE_) begin
         state     <= BUS_SLAVE_STATE_IDLE;
         cnt       <= '0;
         rw_q      <= 1'b0;
         idx_q     <= '0;
         wr_data_q <= '0;
         rdy_q     <= DISABLE_;
      end else begin
         case (state)
            BUS_SLAVE_STATE_IDLE: begin
               if (bus.cs_ == ENABLE_ && bus.as_ == ENABLE_) begin
                  rw_q      <= bus.rw;
                  idx_q     <= bus.addr[ADDR_W+1:2];
                  wr_data_q <= bus.wr_data;
                  cnt       <= WAIT_INIT;
                  state     <= BUS_SLAVE_STATE_ACCESS;
               end
            end
            BUS_SLAVE_STATE_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rdy_q <= ENABLE_;
                  state <= BUS_SLAVE_STATE_DONE;
               end
            end
            BUS_SLAVE_STATE_DONE: begin
               rdy_q <= DISABLE_;
               state <= BUS_SLAVE_STATE_IDLE;
            end
            default: begin
               rdy_q <= DISABLE_;
               state <= BUS_SLAVE_STATE_IDLE;
            end
         endcase
      end
   end

   bus_slave_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .en      (ram_en),
      .we      (rw_q == WRITE),
      .addr    (idx_q),
      .wr_data (wr_data_q),
      .rd_data (ram_rd_data)
   );

   assign bus.rd_data = ram_rd_data;
   assign bus.rdy_    = rdy_q;

endmodule

// File: tb/tb_bus_slave_if.sv
// Scoreboard bench for bus_slave_if: two instances (0 and 3 wait states)
// share clock and reset; expected responses are queued at issue time and
// consumed by a negedge monitor that also checks ready latency.
module tb_bus_slave_if;
   import bus_slave_if_pkg::*;

   localparam int ADDR_W = 10;
   localparam int NWORDS = 1 << ADDR_W;

   typedef struct {
      int          dut;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;

   logic        cs_v   [2];
   logic        as_v   [2];
   logic        rw_v   [2];
   logic [31:0] addr_v [2];
   logic [31:0] wd_v   [2];
   logic        rdy_s  [2];
   logic [31:0] rdd_s  [2];

   logic [31:0] ref_mem [2][NWORDS];
   exp_t        exp_q[$];
   exp_t        mon_e;

   always #5 clk = ~clk;

   // Edge counter: at a negedge it equals the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   bus_slave_if_if bus0 ();
   bus_slave_if_if bus3 ();

   assign bus0.cs_     = cs_v[0];
   assign bus0.as_     = as_v[0];
   assign bus0.rw      = rw_v[0];
   assign bus0.addr    = addr_v[0];
   assign bus0.wr_data = wd_v[0];
   assign bus3.cs_     = cs_v[1];
   assign bus3.as_     = as_v[1];
   assign bus3.rw      = rw_v[1];
   assign bus3.addr    = addr_v[1];
   assign bus3.wr_data = wd_v[1];
   assign rdy_s[0]     = bus0.rdy_;
   assign rdd_s[0]     = bus0.rd_data;
   assign rdy_s[1]     = bus3.rdy_;
   assign rdd_s[1]     = bus3.rd_data;

   bus_slave_if #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   bus_slave_if #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   function automatic int waitOf(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h required %08h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Monitor: every response must match the queue head in owner, cycle and data.
   always @(negedge clk) begin
      if (mon_on) begin
         for (int d = 0; d < 2; d++) begin
            if (rdy_s[d] === 1'b0) begin
               if (exp_q.size() > 0 && exp_q[0].dut == d) begin
                  mon_e = exp_q.pop_front();
                  checkOutput($sformatf("rdy_cycle dut%0d", d), cyc, mon_e.cyc);
                  checkOutput($sformatf("rd_data dut%0d", d), rdd_s[d], mon_e.data);
               end else begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_rdy dut%0d: rdy_ got 0 required 1 (cycle %0d)",
                           d, cyc);
               end
            end else begin
               checkOutput($sformatf("idle_rd_data dut%0d", d), rdd_s[d], 32'h0);
            end
         end
         if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_rdy dut%0d: no rdy_ by cycle %0d, required at %0d",
                     exp_q[0].dut, cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   // Queue the expected response and drive a one-cycle strobe (call at negedge).
   task automatic issueAccess(input int d, input logic rw, input logic [31:0] addr,
                              input logic [31:0] data);
      int   idx;
      exp_t e;
      idx    = int'((addr / 4) % NWORDS);
      e.dut  = d;
      e.cyc  = cyc + 2 + waitOf(d);
      e.data = (rw == READ) ? ref_mem[d][idx] : 32'h0;
      if (rw == WRITE) ref_mem[d][idx] = data;
      exp_q.push_back(e);
      cs_v[d]   = 1'b0;
      as_v[d]   = 1'b0;
      rw_v[d]   = rw;
      addr_v[d] = addr;
      wd_v[d]   = data;
      @(negedge clk);
      cs_v[d]   = 1'b1;
      as_v[d]   = 1'b1;
      rw_v[d]   = 1'($urandom);
      addr_v[d] = $urandom;
      wd_v[d]   = $urandom;
   endtask

   task automatic applyStimulus(input int d, input logic rw, input logic [31:0] addr,
                                input logic [31:0] data);
      issueAccess(d, rw, addr, data);
      repeat (waitOf(d) + 3) @(negedge clk);
   endtask

   // One-cycle drive of cs_/as_ that the slave is expected to ignore.
   task automatic pulseOnly(input int d, input logic cs, input logic as,
                            input logic rw, input logic [31:0] addr,
                            input logic [31:0] data);
      cs_v[d]   = cs;
      as_v[d]   = as;
      rw_v[d]   = rw;
      addr_v[d] = addr;
      wd_v[d]   = data;
      @(negedge clk);
      cs_v[d]   = 1'b1;
      as_v[d]   = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          idx;
      logic        rw;
      logic [31:0] addr;
      int          d;

      // Reset with random bus activity on both slaves.
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cs_v[i]   = 1'($urandom);
         as_v[i]   = 1'($urandom);
         rw_v[i]   = 1'($urandom);
         addr_v[i] = $urandom;
         wd_v[i]   = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      mon_on = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset_rdy dut%0d", i), {31'h0, rdy_s[i]}, 32'h1);
            checkOutput($sformatf("reset_rd_data dut%0d", i), rdd_s[i], 32'h0);
         end
         if (r == 0) @(negedge clk);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cs_v[i] = 1'b1;
         as_v[i] = 1'b1;
      end
      repeat (2) @(negedge clk);

      // Zero wait states: write then read back.
      applyStimulus(0, WRITE, 32'h0800_0010, 32'hDEAD_BEEF);
      applyStimulus(0, READ,  32'h0800_0010, 32'h0);

      // Three wait states: preload then read.
      applyStimulus(1, WRITE, 32'h0000_001C, 32'h1234_5678);
      applyStimulus(1, READ,  32'h0000_001C, 32'h0);

      // Strobes without chip select, and chip select without strobe.
      pulseOnly(0, 1'b1, 1'b0, WRITE, 32'h0000_0010, 32'hBAD0_0001);
      pulseOnly(1, 1'b1, 1'b0, WRITE, 32'h0000_001C, 32'hBAD0_0002);
      repeat (20) @(negedge clk);
      pulseOnly(0, 1'b0, 1'b1, WRITE, 32'h0000_0010, 32'hBAD0_0003);
      pulseOnly(1, 1'b0, 1'b1, WRITE, 32'h0000_001C, 32'hBAD0_0004);
      repeat (20) @(negedge clk);
      applyStimulus(0, READ, 32'h0000_0010, 32'h0);
      applyStimulus(1, READ, 32'h0000_001C, 32'h0);

      // A second strobe (a write) during ACCESS must be dropped.
      issueAccess(1, READ, 32'h0000_001C, 32'h0);
      pulseOnly(1, 1'b0, 1'b0, WRITE, 32'h0000_001C, 32'hBAD0_BAD0);
      repeat (8) @(negedge clk);
      applyStimulus(1, READ, 32'h0000_001C, 32'h0);

      // Reset two edges into a waited write: no ready, no commit.
      pulseOnly(1, 1'b0, 1'b0, WRITE, 32'h0000_001C, 32'hA5A5_A5A5);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      applyStimulus(1, READ, 32'h0000_001C, 32'h0);

      // Index wraps modulo the RAM depth.
      applyStimulus(0, WRITE, 32'h0000_1004, 32'h1111_1111);
      applyStimulus(0, READ,  32'h0000_0004, 32'h0);

      // Random phase: preload a window in both slaves, then mixed traffic.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 32; k++) begin
            addr = ($urandom & 32'hFFFF_F003) | (32'(k) << 2);
            applyStimulus(i, WRITE, addr, $urandom);
         end
      end
      for (int n = 0; n < 80; n++) begin
         d    = int'($urandom_range(0, 1));
         idx  = int'($urandom_range(0, 31));
         rw   = 1'($urandom);
         addr = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
         applyStimulus(d, rw, addr, $urandom);
      end

      repeat (10) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
